// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the fetch front end
package cpu_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_J   = 2'b10,
    PCSRC_JR  = 2'b11
  } pcsrc_e;

  typedef enum logic {
    ST_REQ     = 1'b0,
    ST_DELIVER = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/pc_target_mux.sv
// rtl/pc_target_mux.sv - picks the word-aligned redirect target and flags a redirect
module pc_target_mux
  import cpu_pkg::*;
(
  input  logic [1:0]        PCSrc,
  input  logic              RedirectValid,
  input  logic [WORD_W-1:0] BranchTarget,
  input  logic [WORD_W-1:0] NewJumpADDR,
  input  logic [WORD_W-1:0] JRTarget,
  output logic [WORD_W-1:0] Target,
  output logic              Hit
);
  logic [WORD_W-1:0] raw;

  always_comb begin
    raw = '0;
    case (PCSrc)
      PCSRC_BR: raw = BranchTarget;
      PCSRC_J:  raw = NewJumpADDR;
      PCSRC_JR: raw = JRTarget;
      default:  raw = '0;
    endcase
  end

  // A "sequential" source never redirects, even when qualified
  assign Hit    = RedirectValid && (PCSrc != PCSRC_SEQ);
  assign Target = raw & ~32'h3;
endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, next-PC select and single-outstanding fetch handshake
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Stall,
  input  logic              RedirectValid,
  input  logic [1:0]        PCSrc,
  input  logic [WORD_W-1:0] BranchTarget,
  input  logic [WORD_W-1:0] NewJumpADDR,
  input  logic [WORD_W-1:0] JRTarget,
  output logic              IMemReq,
  output logic [WORD_W-1:0] IMemAddr,
  input  logic              IMemAck,
  input  logic [WORD_W-1:0] IMemRData,
  output logic [WORD_W-1:0] Instr,
  output logic              InstrValid,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] PCPlus4
);
  fetch_state_e      state_q;
  logic              live_q;
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] instr_q;
  logic              valid_q;
  logic              pend_q;
  logic [WORD_W-1:0] pend_tgt_q;
  logic [WORD_W-1:0] tgt;
  logic              hit;

  pc_target_mux u_tgt_mux (
    .PCSrc        (PCSrc),
    .RedirectValid(RedirectValid),
    .BranchTarget (BranchTarget),
    .NewJumpADDR  (NewJumpADDR),
    .JRTarget     (JRTarget),
    .Target       (tgt),
    .Hit          (hit)
  );

  // live_q keeps the request low until the first edge after reset release
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_REQ;
      live_q     <= 1'b0;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else if (!live_q) begin
      live_q <= 1'b1;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (IMemAck) begin
            if (hit) begin
              pc_q   <= tgt;
              pend_q <= 1'b0;
            end else if (pend_q) begin
              pc_q   <= pend_tgt_q;
              pend_q <= 1'b0;
            end else begin
              instr_q <= IMemRData;
              valid_q <= 1'b1;
              state_q <= ST_DELIVER;
            end
          end else if (hit) begin
            pend_q     <= 1'b1;
            pend_tgt_q <= tgt;
          end
        end
        ST_DELIVER: begin
          if (Stall) begin
            if (hit) begin
              pend_q     <= 1'b1;
              pend_tgt_q <= tgt;
            end
          end else begin
            pc_q    <= hit ? tgt : (pend_q ? pend_tgt_q : PCPlus4);
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_REQ;
      endcase
    end
  end

  assign IMemReq    = live_q && (state_q == ST_REQ);
  assign IMemAddr   = pc_q;
  assign PC         = pc_q;
  assign PCPlus4    = pc_q + 32'd4;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed vectors plus random stimulus against a reference model
module tb_pc_fetch_unit;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        Stall = 1'b0;
  logic        RedirectValid = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] BranchTarget = '0;
  logic [31:0] NewJumpADDR = '0;
  logic [31:0] JRTarget = '0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemRData = '0;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_unit #(.RESET_PC(RPC)) dut (
    .CLK(CLK), .RST_N(RST_N), .Stall(Stall), .RedirectValid(RedirectValid),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .NewJumpADDR(NewJumpADDR),
    .JRTarget(JRTarget), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemAck(IMemAck), .IMemRData(IMemRData), .Instr(Instr),
    .InstrValid(InstrValid), .PC(PC), .PCPlus4(PCPlus4)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(logic st, logic rv, logic [1:0] src, logic [31:0] tgt,
                              logic ack, logic [31:0] rd, logic er, logic [31:0] ea,
                              logic ev, logic [31:0] ei);
    vec_t v;
    v.stall = st; v.rv = rv; v.src = src; v.tgt = tgt; v.ack = ack; v.rdata = rd;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Only the selected target carries the real address; the others carry junk
  task automatic drive(input logic st, input logic rv, input logic [1:0] src,
                       input logic [31:0] tgt, input logic ack, input logic [31:0] rd);
    Stall = st; RedirectValid = rv; PCSrc = src; IMemAck = ack; IMemRData = rd;
    BranchTarget = (src == 2'b01) ? tgt : ~tgt;
    NewJumpADDR  = (src == 2'b10) ? tgt : ~tgt;
    JRTarget     = (src == 2'b11) ? tgt : ~tgt;
  endtask

  // Reference model: "have an instruction for decode" vs "fetching", plus one pending redirect
  logic        m_live, m_have, m_pend;
  logic [31:0] m_pc, m_instr, m_pend_tgt;

  task automatic model_reset();
    m_live = 0; m_have = 0; m_pend = 0; m_pc = RPC; m_instr = 0; m_pend_tgt = 0;
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [1:0] src,
                            input logic [31:0] br, input logic [31:0] jt, input logic [31:0] jr,
                            input logic ack, input logic [31:0] rd);
    logic        redir;
    logic [31:0] t;
    redir = rv && (src != 2'd0);
    t = (src == 2'd1) ? br : (src == 2'd2) ? jt : jr;
    t = t - (t % 4);
    if (!m_live) m_live = 1;
    else if (!m_have) begin
      if (ack && redir) begin m_pc = t; m_pend = 0; end
      else if (ack && m_pend) begin m_pc = m_pend_tgt; m_pend = 0; end
      else if (ack) begin m_have = 1; m_instr = rd; end
      else if (redir) begin m_pend = 1; m_pend_tgt = t; end
    end else if (st) begin
      if (redir) begin m_pend = 1; m_pend_tgt = t; end
    end else begin
      m_pc = redir ? t : (m_pend ? m_pend_tgt : (m_pc + 32'd4) % 64'h1_0000_0000);
      m_have = 0; m_pend = 0;
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".req"},   {31'd0, IMemReq},    {31'd0, m_live && !m_have});
    chk({tag, ".addr"},  IMemAddr,            m_pc);
    chk({tag, ".pc"},    PC,                  m_pc);
    chk({tag, ".pc4"},   PCPlus4,             m_pc + 32'd4);
    chk({tag, ".valid"}, {31'd0, InstrValid}, {31'd0, m_have});
    if (m_have) chk({tag, ".instr"}, Instr, m_instr);
  endtask

  initial begin
    vt[0]  = mk(0, 0, 2'd0, 32'h0,         0, 32'h0,         1, 32'h0040_0000, 0, 32'h0);
    vt[1]  = mk(0, 0, 2'd0, 32'h0,         1, 32'h2008_0005, 0, 32'h0040_0000, 1, 32'h2008_0005);
    vt[2]  = mk(0, 0, 2'd0, 32'h0,         0, 32'h0,         1, 32'h0040_0004, 0, 32'h0);
    vt[3]  = mk(0, 0, 2'd0, 32'h0,         1, 32'h1111_1111, 0, 32'h0040_0004, 1, 32'h1111_1111);
    vt[4]  = mk(0, 1, 2'd2, 32'h0040_0103, 0, 32'h0,         1, 32'h0040_0100, 0, 32'h0);
    vt[5]  = mk(0, 0, 2'd0, 32'h0,         1, 32'h2222_2222, 0, 32'h0040_0100, 1, 32'h2222_2222);
    vt[6]  = mk(0, 1, 2'd1, 32'h0040_000B, 0, 32'h0,         1, 32'h0040_0008, 0, 32'h0);
    vt[7]  = mk(0, 1, 2'd1, 32'h0040_0040, 0, 32'h0,         1, 32'h0040_0008, 0, 32'h0);
    vt[8]  = mk(0, 0, 2'd0, 32'h0,         0, 32'h0,         1, 32'h0040_0008, 0, 32'h0);
    vt[9]  = mk(0, 0, 2'd0, 32'h0,         1, 32'hDEAD_BEEF, 1, 32'h0040_0040, 0, 32'h0);
    vt[10] = mk(0, 0, 2'd0, 32'h0,         1, 32'h3333_3333, 0, 32'h0040_0040, 1, 32'h3333_3333);
    vt[11] = mk(1, 0, 2'd0, 32'h0,         0, 32'h0,         0, 32'h0040_0040, 1, 32'h3333_3333);
    vt[12] = mk(1, 1, 2'd3, 32'h0040_0200, 0, 32'h0,         0, 32'h0040_0040, 1, 32'h3333_3333);
    vt[13] = mk(1, 0, 2'd0, 32'h0,         0, 32'h0,         0, 32'h0040_0040, 1, 32'h3333_3333);
    vt[14] = mk(0, 0, 2'd0, 32'h0,         0, 32'h0,         1, 32'h0040_0200, 0, 32'h0);
    vt[15] = mk(0, 1, 2'd0, 32'h1234_5678, 1, 32'h4444_4444, 0, 32'h0040_0200, 1, 32'h4444_4444);
    vt[16] = mk(0, 1, 2'd3, 32'hFFFF_FFFF, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0);
    vt[17] = mk(0, 0, 2'd0, 32'h0,         1, 32'h5555_5555, 0, 32'hFFFF_FFFC, 1, 32'h5555_5555);
    vt[18] = mk(0, 0, 2'd0, 32'h0,         0, 32'h0,         1, 32'h0000_0000, 0, 32'h0);

    // Mid-cycle reset pulse: values must appear while RST_N is still low
    cyc();
    RST_N = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst.pc",    PC,                  RPC);
    chk("rst.instr", Instr,               32'h0);
    chk("rst.valid", {31'd0, InstrValid}, 32'd0);
    chk("rst.req",   {31'd0, IMemReq},    32'd0);
    #1;
    RST_N = 1'b1;
    #1;
    chk("rel.req", {31'd0, IMemReq}, 32'd0);

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].stall, vt[i].rv, vt[i].src, vt[i].tgt, vt[i].ack, vt[i].rdata);
      cyc();
      chk($sformatf("v%0d.req", i),   {31'd0, IMemReq},    {31'd0, vt[i].e_req});
      chk($sformatf("v%0d.addr", i),  IMemAddr,            vt[i].e_addr);
      chk($sformatf("v%0d.pc", i),    PC,                  vt[i].e_addr);
      chk($sformatf("v%0d.valid", i), {31'd0, InstrValid}, {31'd0, vt[i].e_valid});
      if (vt[i].e_valid) chk($sformatf("v%0d.instr", i), Instr, vt[i].e_instr);
    end
    chk("wrap.pc4", PCPlus4, 32'h0000_0004);

    // Reset asserted while in REQ at address 0
    drive(0, 0, 2'd0, 32'h0, 0, 32'h0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rstreq.valid", {31'd0, InstrValid}, 32'd0);
    chk("rstreq.pc",    PC,                  RPC);
    RST_N = 1'b1;

    // Reset asserted in a stalled DELIVER with a redirect pending
    cyc();
    drive(0, 0, 2'd0, 32'h0, 1, 32'hCAFE_0001);
    cyc();
    drive(1, 1, 2'd2, 32'h0040_0300, 0, 32'h0);
    cyc();
    chk("stall.valid", {31'd0, InstrValid}, 32'd1);
    chk("stall.instr", Instr,               32'hCAFE_0001);
    RST_N = 1'b0;
    #1;
    chk("rststall.valid", {31'd0, InstrValid}, 32'd0);
    chk("rststall.pc",    PC,                  RPC);
    chk("rststall.instr", Instr,               32'h0);
    RST_N = 1'b1;
    drive(0, 0, 2'd0, 32'h0, 0, 32'h0);
    cyc();
    cyc();
    chk("postrst.addr", IMemAddr, RPC);
    chk("postrst.req",  {31'd0, IMemReq}, 32'd1);

    // Randomised run against the reference model
    model_reset();
    RST_N = 1'b0;
    #1;
    RST_N = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      logic        st, rv, ack;
      logic [1:0]  src;
      logic [31:0] br, jt, jr, rd;
      if ($urandom_range(199) == 0) begin
        RST_N = 1'b0;
        #1;
        model_reset();
        model_check("rand.rst");
        RST_N = 1'b1;
      end
      st  = ($urandom_range(2) == 0);
      rv  = ($urandom_range(3) == 0);
      src = 2'($urandom_range(3));
      br  = 32'h0040_0000 + 32'($urandom_range(1023));
      jt  = 32'h0080_0000 + 32'($urandom_range(1023));
      jr  = (n % 97 == 0) ? 32'hFFFF_FFFE : $urandom;
      ack = (m_live && !m_have) ? ($urandom_range(1) == 1) : 1'b0;
      rd  = $urandom;
      Stall = st; RedirectValid = rv; PCSrc = src; BranchTarget = br;
      NewJumpADDR = jt; JRTarget = jr; IMemAck = ack; IMemRData = rd;
      model_step(st, rv, src, br, jt, jr, ack, rd);
      cyc();
      model_check($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
